prio_encoder_rr: RTL and testbench

//  Parametrised N-to-log2(N) encoder. Successor to the fixed 8-to-3 encoder.

---
 rtl/prio_encoder_rr_pkg.sv | 9 +
 rtl/prio_scan_rr.sv | 36 +++
 rtl/prio_encoder_rr.sv | 71 +++++++
 tb/tb_prio_encoder_rr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// rtl/prio_encoder_rr_pkg.sv - shared types for the parametrised priority encoder
package prio_encoder_rr_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } prio_mode_e;

endpackage

// File: rtl/prio_scan_rr.sv
// rtl/prio_scan_rr.sv - combinational request scan, fixed (highest index) or rotating start
module prio_scan_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         dir_fixed,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         multi
);

  logic [W:0] pos;

  always_comb begin
    idx = '0;
    pos = '0;
    if (dir_fixed) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end else begin
      // walk backwards so the candidate nearest to start is written last
      for (int k = N - 1; k >= 0; k--) begin
        pos = {1'b0, start} + (W+1)'(k);
        if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
        if (req[pos[W-1:0]]) idx = pos[W-1:0];
      end
    end
  end

  assign found = |req;
  assign multi = (req & (req - N'(1))) != '0;

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered N-to-log2(N) encoder with handshake and round-robin pointer
module prio_encoder_rr
  import prio_encoder_rr_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_adv;
  logic [W-1:0] scan_start;
  logic [W-1:0] scan_idx;
  logic         scan_found;
  logic         scan_multi;
  logic         held_rr;
  logic         load;
  logic         xfer_rr;

  assign load    = !out_valid || out_ready;
  assign xfer_rr = out_valid && out_ready && held_rr;
  assign ptr_adv = (idx == W'(N - 1)) ? '0 : idx + W'(1);
  // scan from the advanced pointer when a transfer and a reload share a cycle
  assign scan_start = xfer_rr ? ptr_adv : ptr;

  prio_scan_rr #(.N(N)) u_scan (
    .req       (req),
    .start     (scan_start),
    .dir_fixed (mode == MODE_FIXED),
    .idx       (scan_idx),
    .found     (scan_found),
    .multi     (scan_multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      idx       <= '0;
      grant     <= '0;
      multi     <= 1'b0;
      ptr       <= '0;
      held_rr   <= 1'b0;
    end else begin
      if (xfer_rr) ptr <= ptr_adv;
      if (load) begin
        if (scan_found) begin
          out_valid <= 1'b1;
          idx       <= scan_idx;
          grant     <= N'(1) << scan_idx;
          multi     <= scan_multi;
          held_rr   <= (mode == MODE_RR);
        end else begin
          out_valid <= 1'b0;
          grant     <= '0;
          multi     <= 1'b0;
          held_rr   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - self-checking bench for prio_encoder_rr (N=8 and N=5)
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       out_ready;
  logic [7:0] req_a;
  logic [4:0] req_b;
  logic       valid_a, multi_a, valid_b, multi_b;
  logic [2:0] idx_a, idx_b;
  logic [7:0] grant_a;
  logic [4:0] grant_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .mode(mode), .out_ready(out_ready),
    .out_valid(valid_a), .idx(idx_a), .grant(grant_a), .multi(multi_a)
  );

  prio_encoder_rr #(.N(5)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .mode(mode), .out_ready(out_ready),
    .out_valid(valid_b), .idx(idx_b), .grant(grant_b), .multi(multi_b)
  );

  // reference model: what the consumer should see, plus the rotation pointer
  typedef struct {
    bit valid;
    int idx;
    bit multi;
    int ptr;
    bit rr;
  } mstate_t;

  mstate_t ma, mb;

  function automatic int pick(logic [7:0] r, bit m, int p, int n);
    if (!m) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit r_st, logic [7:0] r, bit m, bit rdy, int n);
    mstate_t t;
    int sel;
    t = s;
    if (r_st) begin
      t = '{valid: 0, idx: 0, multi: 0, ptr: 0, rr: 0};
      return t;
    end
    if (s.valid && rdy && s.rr) t.ptr = (s.idx + 1) % n;
    if (!s.valid || rdy) begin
      sel = pick(r, m, t.ptr, n);
      if (sel < 0) begin
        t.valid = 0; t.multi = 0; t.rr = 0;
      end else begin
        t.valid = 1; t.idx = sel; t.multi = ($countones(r) > 1); t.rr = m;
      end
    end
    return t;
  endfunction

  always @(posedge clk) begin
    ma <= model_next(ma, rst, req_a, mode, out_ready, 8);
    mb <= model_next(mb, rst, {3'b000, req_b}, mode, out_ready, 5);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; req_a = 8'hFF; req_b = 5'h1F; out_ready = 1; mode = 0;
    cyc(); cyc();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (grant_a !== 8'h00) begin errors++; $display("FAIL reset_grant got=%h exp=00", grant_a); end
    checks++; if (multi_a !== 1'b0) begin errors++; $display("FAIL reset_multi got=%b exp=0", multi_a); end
    checks++; if (idx_a !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
    rst = 0;
    cyc();
    checks++; if (valid_a !== 1'b1 || idx_a !== 3'd7) begin
      errors++; $display("FAIL post_reset_idx got=%b/%0d exp=1/7", valid_a, idx_a);
    end
    checks++; if (multi_a !== 1'b1) begin errors++; $display("FAIL post_reset_multi got=%b exp=1", multi_a); end
    req_b = 5'h00;
  endtask

  task automatic test_one_hot_sweep();
    logic [2:0] e;
    mode = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      req_a = 8'h01 << i;
      cyc();
      e = 3'(i);
      checks++; if (valid_a !== 1'b1 || idx_a !== e || multi_a !== 1'b0 || grant_a !== req_a) begin
        errors++;
        $display("FAIL sweep_%0d got v=%b idx=%0d m=%b g=%h exp v=1 idx=%0d m=0 g=%h",
                 i, valid_a, idx_a, multi_a, grant_a, i, req_a);
      end
    end
  endtask

  task automatic test_fixed_multi();
    mode = 0; out_ready = 1; req_a = 8'b1000_0001;
    cyc();
    checks++; if (idx_a !== 3'd7 || multi_a !== 1'b1 || grant_a !== 8'h80) begin
      errors++; $display("FAIL fixed_multi got idx=%0d m=%b g=%h exp idx=7 m=1 g=80", idx_a, multi_a, grant_a);
    end
    req_a = 8'h00;
    cyc();
    checks++; if (valid_a !== 1'b0 || grant_a !== 8'h00 || multi_a !== 1'b0 || idx_a !== 3'd7) begin
      errors++; $display("FAIL fixed_empty got v=%b g=%h m=%b idx=%0d exp v=0 g=00 m=0 idx=7",
                         valid_a, grant_a, multi_a, idx_a);
    end
  endtask

  task automatic test_rr_fairness();
    int seq[5] = '{0, 3, 7, 0, 3};
    logic [2:0] e;
    mode = 1; out_ready = 1; req_a = 8'b1000_1001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      e = 3'(seq[i]);
      checks++; if (valid_a !== 1'b1 || idx_a !== e || multi_a !== 1'b1) begin
        errors++; $display("FAIL rr_seq_%0d got v=%b idx=%0d m=%b exp v=1 idx=%0d m=1",
                           i, valid_a, idx_a, multi_a, seq[i]);
      end
      if (i == 3) begin
        checks++; if (dut_a.ptr !== 3'd0) begin errors++; $display("FAIL rr_ptr_wrap got=%0d exp=0", dut_a.ptr); end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0; req_a = 8'h40; mode = 0;
    cyc();
    checks++; if (valid_a !== 1'b1 || idx_a !== 3'd3 || grant_a !== 8'h08) begin
      errors++; $display("FAIL bp_hold1 got v=%b idx=%0d g=%h exp v=1 idx=3 g=08", valid_a, idx_a, grant_a);
    end
    mode = 1;
    cyc();
    checks++; if (valid_a !== 1'b1 || idx_a !== 3'd3) begin
      errors++; $display("FAIL bp_hold2 got v=%b idx=%0d exp v=1 idx=3", valid_a, idx_a);
    end
    out_ready = 1;
    cyc();
    checks++; if (valid_a !== 1'b1 || idx_a !== 3'd6 || multi_a !== 1'b0) begin
      errors++; $display("FAIL bp_release got v=%b idx=%0d m=%b exp v=1 idx=6 m=0", valid_a, idx_a, multi_a);
    end
    req_a = 8'h00;
  endtask

  task automatic test_non_pow2();
    int seq[3] = '{0, 4, 0};
    logic [2:0] e;
    rst = 1; cyc(); rst = 0;
    mode = 1; out_ready = 1; req_b = 5'b10001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = 3'(seq[i]);
      checks++; if (valid_b !== 1'b1 || idx_b !== e || dut_b.ptr > 3'd4) begin
        errors++; $display("FAIL n5_seq_%0d got v=%b idx=%0d ptr=%0d exp v=1 idx=%0d ptr<=4",
                           i, valid_b, idx_b, dut_b.ptr, seq[i]);
      end
    end
    out_ready = 0; req_b = 5'b00010;
    cyc();
    checks++; if (valid_b !== 1'b1 || idx_b !== 3'd0) begin
      errors++; $display("FAIL n5_stall got v=%b idx=%0d exp v=1 idx=0", valid_b, idx_b);
    end
    rst = 1;
    cyc();
    checks++; if (valid_b !== 1'b0 || dut_b.ptr !== 3'd0 || grant_b !== 5'd0) begin
      errors++; $display("FAIL n5_rst_stall got v=%b ptr=%0d g=%h exp v=0 ptr=0 g=00", valid_b, dut_b.ptr, grant_b);
    end
    rst = 0; out_ready = 1; req_b = 5'd0;
  endtask

  task automatic test_random();
    int ga, gb;
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      req_a     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      req_b     = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
      cyc();
      ga = ma.valid ? (1 << ma.idx) : 0;
      gb = mb.valid ? (1 << mb.idx) : 0;
      checks++; if (valid_a !== ma.valid || int'(idx_a) != ma.idx || multi_a !== ma.multi ||
                    int'(grant_a) != ga || int'(dut_a.ptr) != ma.ptr) begin
        errors++; $display("FAIL rand_a_%0d got v=%b idx=%0d m=%b g=%h ptr=%0d exp v=%b idx=%0d m=%b g=%h ptr=%0d",
                           c, valid_a, idx_a, multi_a, grant_a, dut_a.ptr, ma.valid, ma.idx, ma.multi, ga, ma.ptr);
      end
      checks++; if (valid_b !== mb.valid || int'(idx_b) != mb.idx || multi_b !== mb.multi ||
                    int'(grant_b) != gb || int'(dut_b.ptr) != mb.ptr) begin
        errors++; $display("FAIL rand_b_%0d got v=%b idx=%0d m=%b g=%h ptr=%0d exp v=%b idx=%0d m=%b g=%h ptr=%0d",
                           c, valid_b, idx_b, multi_b, grant_b, dut_b.ptr, mb.valid, mb.idx, mb.multi, gb, mb.ptr);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; mode = 0; out_ready = 1; req_a = 8'h00; req_b = 5'h00;
    @(negedge clk);
    test_reset();
    test_one_hot_sweep();
    test_fixed_multi();
    test_rr_fairness();
    test_backpressure();
    test_non_pow2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
